// File: rtl/pc_sequencer.sv
// Program counter control sequencer: issues PCL/PCH select, increment and bus strobes for
// single-cycle ops, PC pushes and vector loads. Optional mem_ack timeout: PC_SEQ_TIMEOUT_EN.
module pc_sequencer #(
    parameter logic [15:0] VEC_NMI        = 16'hFFFA,
    parameter logic [15:0] VEC_RES        = 16'hFFFC,
    parameter logic [15:0] VEC_IRQ        = 16'hFFFE,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        phi_2,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [2:0]  cmd,
    input  logic [1:0]  vec_sel,
    output logic        cmd_ready,
    input  logic        mem_ack,
    output logic        pcl_pcl,
    output logic        adl_pcl,
    output logic        pch_pch,
    output logic        adh_pch,
    output logic        i_pc,
    output logic        pcl_db,
    output logic        pch_db,
    output logic        pcl_adl,
    output logic        pch_adh,
    output logic        vec_oe,
    output logic [15:0] vec_addr,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE, S_ONE, S_PUSH_H, S_PUSH_L, S_VL_REQ, S_VL_LD, S_VH_REQ, S_VH_LD
    } state_t;

    typedef enum logic [2:0] {
        CMD_HOLD, CMD_INC, CMD_JUMP, CMD_JUMP_INC, CMD_PUSH, CMD_VECTOR, CMD_FETCH, CMD_ILLEGAL
    } cmd_t;

    state_t      state, nxt_state;
    logic [15:0] vec_base, nxt_base;
    logic        accept;
    logic        timed_out;

    logic        n_cmd_ready, n_pcl_pcl, n_adl_pcl, n_pch_pch, n_adh_pch, n_i_pc;
    logic        n_pcl_db, n_pch_db, n_pcl_adl, n_pch_adh, n_vec_oe, n_busy, n_done, n_err;
    logic [15:0] n_vec_addr;

`ifdef PC_SEQ_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WAIT_W-1:0] wait_cnt;

    assign timed_out = !mem_ack && (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge phi_2) begin
        if (reset || (state != nxt_state)) begin
            wait_cnt <= '0;
        end else if (state == S_VL_REQ || state == S_VH_REQ) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    assign timed_out = 1'b0;
`endif

    assign accept = cmd_valid && cmd_ready;

    always_comb begin
        nxt_state  = state;
        nxt_base   = vec_base;
        n_pcl_pcl  = 1'b1;
        n_adl_pcl  = 1'b0;
        n_pch_pch  = 1'b1;
        n_adh_pch  = 1'b0;
        n_i_pc     = 1'b0;
        n_pcl_db   = 1'b0;
        n_pch_db   = 1'b0;
        n_pcl_adl  = 1'b0;
        n_pch_adh  = 1'b0;
        n_vec_oe   = 1'b0;
        n_vec_addr = '0;
        n_busy     = 1'b0;
        n_done     = 1'b0;
        n_err      = 1'b0;

        // Single-cycle strobes are decided here; multi-cycle strobes follow from nxt_state below.
        unique case (state)
            S_IDLE, S_ONE: begin
                nxt_state = S_IDLE;
                if (accept) begin
                    unique case (cmd_t'(cmd))
                        CMD_HOLD: begin
                            nxt_state = S_ONE;
                            n_done    = 1'b1;
                        end
                        CMD_INC: begin
                            nxt_state = S_ONE;
                            n_i_pc    = 1'b1;
                            n_done    = 1'b1;
                        end
                        CMD_JUMP, CMD_JUMP_INC: begin
                            nxt_state = S_ONE;
                            n_adl_pcl = 1'b1;
                            n_pcl_pcl = 1'b0;
                            n_adh_pch = 1'b1;
                            n_pch_pch = 1'b0;
                            n_i_pc    = (cmd_t'(cmd) == CMD_JUMP_INC);
                            n_done    = 1'b1;
                        end
                        CMD_FETCH: begin
                            nxt_state = S_ONE;
                            n_pcl_adl = 1'b1;
                            n_pch_adh = 1'b1;
                            n_i_pc    = 1'b1;
                            n_done    = 1'b1;
                        end
                        CMD_PUSH: nxt_state = S_PUSH_H;
                        CMD_VECTOR: begin
                            unique case (vec_sel)
                                2'd0:    begin nxt_base = VEC_NMI; nxt_state = S_VL_REQ; end
                                2'd1:    begin nxt_base = VEC_RES; nxt_state = S_VL_REQ; end
                                2'd2:    begin nxt_base = VEC_IRQ; nxt_state = S_VL_REQ; end
                                default: n_err = 1'b1;
                            endcase
                        end
                        default: n_err = 1'b1;
                    endcase
                end
            end
            S_PUSH_H: nxt_state = S_PUSH_L;
            S_PUSH_L: nxt_state = S_IDLE;
            S_VL_REQ: begin
                if (mem_ack) begin
                    nxt_state = S_VL_LD;
                end else if (timed_out) begin
                    nxt_state = S_IDLE;
                    n_err     = 1'b1;
                end
            end
            S_VL_LD: nxt_state = S_VH_REQ;
            S_VH_REQ: begin
                if (mem_ack) begin
                    nxt_state = S_VH_LD;
                end else if (timed_out) begin
                    nxt_state = S_IDLE;
                    n_err     = 1'b1;
                end
            end
            S_VH_LD: nxt_state = S_IDLE;
            default: nxt_state = S_IDLE;
        endcase

        unique case (nxt_state)
            S_PUSH_H: begin
                n_pch_db = 1'b1;
                n_busy   = 1'b1;
            end
            S_PUSH_L: begin
                n_pcl_db = 1'b1;
                n_done   = 1'b1;
                n_busy   = 1'b1;
            end
            S_VL_REQ: begin
                n_vec_oe   = 1'b1;
                n_vec_addr = nxt_base;
                n_busy     = 1'b1;
            end
            S_VL_LD: begin
                n_adl_pcl = 1'b1;
                n_pcl_pcl = 1'b0;
                n_busy    = 1'b1;
            end
            S_VH_REQ: begin
                n_vec_oe   = 1'b1;
                n_vec_addr = nxt_base + 16'd1;
                n_busy     = 1'b1;
            end
            S_VH_LD: begin
                n_adh_pch = 1'b1;
                n_pch_pch = 1'b0;
                n_done    = 1'b1;
                n_busy    = 1'b1;
            end
            default: ;
        endcase

        n_cmd_ready = (nxt_state == S_IDLE) || (nxt_state == S_ONE);
    end

    always_ff @(posedge phi_2) begin
        if (reset) begin
            state     <= S_IDLE;
            vec_base  <= '0;
            cmd_ready <= 1'b0;
            pcl_pcl   <= 1'b1;
            adl_pcl   <= 1'b0;
            pch_pch   <= 1'b1;
            adh_pch   <= 1'b0;
            i_pc      <= 1'b0;
            pcl_db    <= 1'b0;
            pch_db    <= 1'b0;
            pcl_adl   <= 1'b0;
            pch_adh   <= 1'b0;
            vec_oe    <= 1'b0;
            vec_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= nxt_state;
            vec_base  <= nxt_base;
            cmd_ready <= n_cmd_ready;
            pcl_pcl   <= n_pcl_pcl;
            adl_pcl   <= n_adl_pcl;
            pch_pch   <= n_pch_pch;
            adh_pch   <= n_adh_pch;
            i_pc      <= n_i_pc;
            pcl_db    <= n_pcl_db;
            pch_db    <= n_pch_db;
            pcl_adl   <= n_pcl_adl;
            pch_adh   <= n_pch_adh;
            vec_oe    <= n_vec_oe;
            vec_addr  <= n_vec_addr;
            busy      <= n_busy;
            done      <= n_done;
            err       <= n_err;
        end
    end

endmodule
